weight_pingpong_ctrl: RTL and testbench
=======================================

WEIGHT_PINGPONG_CTRL -- requirements
Module: weight_pingpong_ctrl

Interface
REQ-001 Parameters: ADDR_W, default 14, weight memory word address width; DATA_W, default 32, external write word width (4 x 8-bit weights).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low.
REQ-004 mode  input  3  0 = FC, 1 = CNN; other values: rd_start/ld_start rejected with err.
REQ-005 ld_start  input  1  begin load of ld_len words into the current fill bank.
REQ-006 ld_len  input  ADDR_W  words to load; legal 1..2^(ADDR_W-1).
REQ-007 ld_valid / ld_ready / ld_data  in / out / in  1 / 1 / DATA_W  load stream; beat transfers when both high.
REQ-008 wr_en_fc, wr_en_cnn  output  1 each  write strobes to weight memory; at most one high, chosen by latched mode.
REQ-009 wr_addr / wr_data  output  ADDR_W / DATA_W  write address {fill_bank, offset}, data = ld_data of transferring beat.
REQ-010 rd_start / rd_len / rd_stall  input  1 / ADDR_W / 1  begin read sequence / beats / hold reads.
REQ-011 rd_en / rd_addr  output  1 / ADDR_W  read strobe, bank-relative beat index.
REQ-012 weight_memory_pointer  output  ADDR_W  bank base: 0 for bank 0; bank 1 = 512 in FC, 2048 in CNN.
REQ-013 bank_full  output  2  per-bank valid-data flags; ld_busy, rd_busy output 1 each; ld_done, rd_done, err output 1-cycle pulses.

Function
REQ-014 Loader FSM states LD_IDLE, LD_RUN; reader FSM states RD_IDLE, RD_RUN, RD_DRAIN.
REQ-015 fill_bank and read_bank pointers, both 0 after reset; each toggles on completion of its own operation.
REQ-016 ld_start accepted in LD_IDLE only if bank_full[fill_bank]==0, mode legal, ld_len legal; latches mode and ld_len, enters LD_RUN.
REQ-017 In LD_RUN, ld_ready=1; each transfer asserts the mode-selected wr_en in the same cycle, wr_addr = {fill_bank, offset}, offset increments from 0.
REQ-018 On the transfer with offset == ld_len-1: wr_en for that beat, ld_done pulse next cycle, bank_full[fill_bank] set, fill_bank toggles, return to LD_IDLE.
REQ-019 rd_start accepted in RD_IDLE only if bank_full[read_bank]==1, mode legal, rd_len in 1..512 (FC) or 1..2048 (CNN); latches mode and rd_len.
REQ-020 In RD_RUN: rd_en=1 when rd_stall=0; rd_addr starts at 0, +1 per issued beat; rd_stall=1 forces rd_en=0 and holds rd_addr.
REQ-021 weight_memory_pointer is held constant from rd_start acceptance until RD_DRAIN exits.
REQ-022 After the beat with rd_addr == rd_len-1, enter RD_DRAIN for exactly one cycle (read data latency 1); then rd_done pulse, clear bank_full[read_bank], toggle read_bank, return to RD_IDLE.
REQ-023 A rejected ld_start or rd_start produces a 1-cycle err pulse and no state change; a start while busy is ignored with err.
REQ-024 Bank release at end of RD_DRAIN is visible combinationally to a same-cycle ld_start, which is accepted.
REQ-025 Load completion in cycle N is not visible to rd_start in cycle N; bank_full is set at N+1, so that rd_start is rejected.
REQ-026 Loader and reader run concurrently on opposite banks; a write and a read never target the same bank in one cycle.
REQ-027 Offset and rd_addr counters never wrap; the length checks guarantee termination before overflow.

Reset
REQ-028 Reset asserted: FSMs idle; pointers 0; bank_full 0; all strobes, pulses, ld_ready, counters, wr_addr, wr_data, rd_addr, pointer 0.
REQ-029 Reset mid-operation discards the partial load or read; bank_full is not set for the aborted bank.

Structure
REQ-030 MODE_FC, MODE_CNN, ADDR_W, DATA_W, per-mode bank-1 pointer constants and FSM state enums live in the shared parameters package.
REQ-031 Single sub-module ping_pong_bank_tracker holding bank_full, fill_bank and read_bank, with set/release ports.

Verification
REQ-032 FC: load 16 words into bank 0 -> wr_en_fc at wr_addr 0..15, ld_done, bank_full=01; rd_start rd_len=1 -> rd_en at rd_addr 0, pointer 0, rd_done 2 cycles after rd_en, bank_full=00.
REQ-033 CNN ping-pong: load bank 0, then read bank 0 while loading bank 1 -> wr_addr 8192.., pointer 2048 on next read, no same-bank collision.
REQ-034 rd_stall toggled every other cycle with rd_len=8 -> rd_addr 0..7 issued without gaps or repeats, 8 rd_en total.
REQ-035 Illegal: ld_len=0, rd_len=513 in FC, rd_start on empty bank, mode=3 -> err pulse each, no strobes.
REQ-036 Same-cycle release plus ld_start accepted; load done plus same-cycle rd_start rejected; reset mid-load at offset 5 -> bank_full=00, all outputs 0.

Source files
------------

// File: rtl/weight_pingpong_ctrl_pkg.sv
// Shared constants for the weight ping-pong controller: widths, mode codes,
// bank geometry and FSM state encodings.
package weight_pingpong_ctrl_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  localparam logic [2:0] MODE_FC  = 3'd0;
  localparam logic [2:0] MODE_CNN = 3'd1;

  // Bank-1 base address seen by the read side, and the matching read length limit
  localparam int BANK1_PTR_FC  = 512;
  localparam int BANK1_PTR_CNN = 2048;

  // Loader FSM
  localparam logic [0:0] LD_IDLE = 1'b0;
  localparam logic [0:0] LD_RUN  = 1'b1;

  // Reader FSM
  localparam logic [1:0] RD_IDLE  = 2'd0;
  localparam logic [1:0] RD_RUN   = 2'd1;
  localparam logic [1:0] RD_DRAIN = 2'd2;

  function automatic logic mode_legal(input logic [2:0] m);
    return (m == MODE_FC) || (m == MODE_CNN);
  endfunction

endpackage

// File: rtl/weight_pingpong_ctrl_bank_tracker.sv
// Tracks which of the two weight banks hold valid data, which bank the loader
// fills next and which bank the reader drains next.
module ping_pong_bank_tracker
  import weight_pingpong_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_commit,   // last beat of a load: mark fill bank full, advance
  input  logic       rd_release,  // final drain cycle: mark read bank empty, advance
  output logic [1:0] bank_full,
  output logic       fill_bank,
  output logic       read_bank,
  output logic       fill_free    // fill bank usable now, counting a same-cycle release
);

  logic [1:0] bank_full_reg;
  logic [1:0] bank_full_next;
  logic       fill_bank_reg;
  logic       read_bank_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      // Commit wins over release; they never address the same bank in one cycle
      assign bank_full_next[gi] =
        (ld_commit && (fill_bank_reg == 1'(gi)))  ? 1'b1 :
        (rd_release && (read_bank_reg == 1'(gi))) ? 1'b0 :
                                                    bank_full_reg[gi];
    end
  endgenerate

  // Bank flags and pointers advance only when their own operation completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_full_reg <= 2'b00;
      fill_bank_reg <= 1'b0;
      read_bank_reg <= 1'b0;
    end else begin
      bank_full_reg <= bank_full_next;
      if (ld_commit)
        fill_bank_reg <= ~fill_bank_reg;
      if (rd_release)
        read_bank_reg <= ~read_bank_reg;
    end
  end

  assign bank_full = bank_full_reg;
  assign fill_bank = fill_bank_reg;
  assign read_bank = read_bank_reg;
  assign fill_free = !bank_full_reg[fill_bank_reg] ||
                     (rd_release && (read_bank_reg == fill_bank_reg));

endmodule

// File: rtl/weight_pingpong_ctrl.sv
// Ping-pong controller for the weight memory: a loader streams words into the
// fill bank while a reader sequences reads out of the other, full bank.
module weight_pingpong_ctrl #(
  parameter int ADDR_W = weight_pingpong_ctrl_pkg::ADDR_W,
  parameter int DATA_W = weight_pingpong_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        mode,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              wr_en_fc,
  output logic              wr_en_cnn,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_len,
  input  logic              rd_stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] weight_memory_pointer,
  output logic [1:0]        bank_full,
  output logic              ld_busy,
  output logic              rd_busy,
  output logic              ld_done,
  output logic              rd_done,
  output logic              err
);

  import weight_pingpong_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] ONE        = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] LD_LEN_MAX = {1'b1, {(ADDR_W-1){1'b0}}};

  logic              ld_state_reg;
  logic [2:0]        ld_mode_reg;
  logic [ADDR_W-1:0] ld_len_reg;
  logic [ADDR_W-1:0] ld_offset_reg;
  logic [1:0]        rd_state_reg;
  logic [2:0]        rd_mode_reg;
  logic [ADDR_W-1:0] rd_len_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic              ld_done_reg;
  logic              rd_done_reg;
  logic              err_reg;

  logic              fill_bank;
  logic              read_bank;
  logic              fill_free;
  logic [ADDR_W-1:0] rd_len_max;
  logic              ld_accept;
  logic              rd_accept;
  logic              ld_xfer;
  logic              ld_last;
  logic              rd_issue;
  logic              rd_last;
  logic              rd_release;

  ping_pong_bank_tracker u_tracker (
    .clk        (clk),
    .reset      (reset),
    .ld_commit  (ld_last),
    .rd_release (rd_release),
    .bank_full  (bank_full),
    .fill_bank  (fill_bank),
    .read_bank  (read_bank),
    .fill_free  (fill_free)
  );

  // Start qualification and per-cycle handshake decode
  always_comb begin
    rd_len_max = (mode == MODE_CNN) ? ADDR_W'(BANK1_PTR_CNN) : ADDR_W'(BANK1_PTR_FC);
    ld_accept  = ld_start && (ld_state_reg == LD_IDLE) && fill_free && mode_legal(mode) &&
                 (ld_len != '0) && (ld_len <= LD_LEN_MAX);
    rd_accept  = rd_start && (rd_state_reg == RD_IDLE) && bank_full[read_bank] &&
                 mode_legal(mode) && (rd_len != '0) && (rd_len <= rd_len_max);
    ld_xfer    = (ld_state_reg == LD_RUN) && ld_valid;
    ld_last    = ld_xfer && (ld_offset_reg == ld_len_reg - ONE);
    rd_issue   = (rd_state_reg == RD_RUN) && !rd_stall;
    rd_last    = rd_issue && (rd_addr_reg == rd_len_reg - ONE);
    rd_release = (rd_state_reg == RD_DRAIN);
  end

  // Loader: latch the request, then count accepted beats up to ld_len
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state_reg  <= LD_IDLE;
      ld_mode_reg   <= MODE_FC;
      ld_len_reg    <= '0;
      ld_offset_reg <= '0;
      ld_done_reg   <= 1'b0;
    end else begin
      ld_done_reg <= ld_last;
      if (ld_state_reg == LD_IDLE) begin
        if (ld_accept) begin
          ld_state_reg  <= LD_RUN;
          ld_mode_reg   <= mode;
          ld_len_reg    <= ld_len;
          ld_offset_reg <= '0;
        end
      end else if (ld_xfer) begin
        if (ld_last) begin
          ld_state_reg  <= LD_IDLE;
          ld_offset_reg <= '0;
        end else begin
          ld_offset_reg <= ld_offset_reg + ONE;
        end
      end
    end
  end

  // Reader: issue rd_len beats around stalls, then one drain cycle for read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_reg <= RD_IDLE;
      rd_mode_reg  <= MODE_FC;
      rd_len_reg   <= '0;
      rd_addr_reg  <= '0;
      rd_done_reg  <= 1'b0;
    end else begin
      rd_done_reg <= rd_release;
      case (rd_state_reg)
        RD_IDLE: begin
          if (rd_accept) begin
            rd_state_reg <= RD_RUN;
            rd_mode_reg  <= mode;
            rd_len_reg   <= rd_len;
            rd_addr_reg  <= '0;
          end
        end
        RD_RUN: begin
          if (rd_issue) begin
            if (rd_last)
              rd_state_reg <= RD_DRAIN;
            else
              rd_addr_reg <= rd_addr_reg + ONE;
          end
        end
        RD_DRAIN: begin
          rd_state_reg <= RD_IDLE;
          rd_addr_reg  <= '0;
        end
        default: rd_state_reg <= RD_IDLE;
      endcase
    end
  end

  // Any rejected start (illegal or while busy) gives a single-cycle error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_reg <= 1'b0;
    else
      err_reg <= (ld_start && !ld_accept) || (rd_start && !rd_accept);
  end

  assign ld_ready  = (ld_state_reg == LD_RUN);
  assign ld_busy   = (ld_state_reg == LD_RUN);
  assign wr_en_fc  = ld_xfer && (ld_mode_reg == MODE_FC);
  assign wr_en_cnn = ld_xfer && (ld_mode_reg == MODE_CNN);
  assign wr_addr   = ld_xfer ? {fill_bank, ld_offset_reg[ADDR_W-2:0]} : '0;
  assign wr_data   = ld_xfer ? ld_data : '0;

  assign rd_busy = (rd_state_reg != RD_IDLE);
  assign rd_en   = rd_issue;
  assign rd_addr = rd_addr_reg;
  // read_bank only moves when the drain ends, so the base is stable for a whole read
  assign weight_memory_pointer = !read_bank ? '0 :
                                 (rd_mode_reg == MODE_CNN) ? ADDR_W'(BANK1_PTR_CNN) :
                                                             ADDR_W'(BANK1_PTR_FC);

  assign ld_done = ld_done_reg;
  assign rd_done = rd_done_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_weight_pingpong_ctrl.sv
// Directed bench for weight_pingpong_ctrl. Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well clear of the rising edge.
module tb_weight_pingpong_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  mode;
  logic        ld_start;
  logic [13:0] ld_len;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        wr_en_fc;
  logic        wr_en_cnn;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_start;
  logic [13:0] rd_len;
  logic        rd_stall;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic [13:0] weight_memory_pointer;
  logic [1:0]  bank_full;
  logic        ld_busy;
  logic        rd_busy;
  logic        ld_done;
  logic        rd_done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int issued;
  int exp_addr;

  weight_pingpong_ctrl dut (
    .clk                   (clk),
    .reset                 (reset),
    .mode                  (mode),
    .ld_start              (ld_start),
    .ld_len                (ld_len),
    .ld_valid              (ld_valid),
    .ld_ready              (ld_ready),
    .ld_data               (ld_data),
    .wr_en_fc              (wr_en_fc),
    .wr_en_cnn             (wr_en_cnn),
    .wr_addr               (wr_addr),
    .wr_data               (wr_data),
    .rd_start              (rd_start),
    .rd_len                (rd_len),
    .rd_stall              (rd_stall),
    .rd_en                 (rd_en),
    .rd_addr               (rd_addr),
    .weight_memory_pointer (weight_memory_pointer),
    .bank_full             (bank_full),
    .ld_busy               (ld_busy),
    .rd_busy               (rd_busy),
    .ld_done               (ld_done),
    .rd_done               (rd_done),
    .err                   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ld_start = 1'b0;
    ld_len   = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    rd_start = 1'b0;
    rd_len   = '0;
    rd_stall = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    mode = 3'd0;
    clear_inputs();
    reset = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    #1;
    // ---- reset state ----
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_wr_en", {wr_en_fc, wr_en_cnn}, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd", {rd_en, rd_addr}, 0);
    chk("rst_ptr", weight_memory_pointer, 0);
    chk("rst_bank_full", bank_full, 0);
    chk("rst_status", {ld_busy, rd_busy, ld_done, rd_done, err}, 0);
    do_reset();

    // ---- FC: 16-word load into bank 0, then a 1-beat read ----
    mode = 3'd0; ld_len = 14'd16; ld_start = 1'b1;
    #1; chk("fc_ready_before_accept", ld_ready, 0);
    @(negedge clk); ld_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1; ld_data = 32'hA000_0000 + i;
      #1;
      chk("fc_wr_en_fc", wr_en_fc, 1);
      chk("fc_wr_en_cnn", wr_en_cnn, 0);
      chk("fc_wr_addr", wr_addr, i);
      chk("fc_wr_data", wr_data, 32'hA000_0000 + i);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    #1;
    chk("fc_ld_done", ld_done, 1);
    chk("fc_bank_full", bank_full, 2'b01);
    chk("fc_ld_busy", ld_busy, 0);
    chk("fc_no_wr", wr_en_fc, 0);
    @(negedge clk); #1;
    chk("fc_ld_done_pulse", ld_done, 0);
    rd_start = 1'b1; rd_len = 14'd1;
    @(negedge clk); rd_start = 1'b0; #1;
    chk("fc_rd_en", rd_en, 1);
    chk("fc_rd_addr", rd_addr, 0);
    chk("fc_ptr", weight_memory_pointer, 0);
    @(negedge clk); #1;
    chk("fc_drain_rd_en", rd_en, 0);
    chk("fc_drain_full", bank_full, 2'b01);
    chk("fc_drain_done", rd_done, 0);
    @(negedge clk); #1;
    chk("fc_rd_done", rd_done, 1);
    chk("fc_released", bank_full, 2'b00);
    chk("fc_rd_busy", rd_busy, 0);
    do_reset();

    // ---- CNN ping-pong: read bank 0 while loading bank 1 ----
    mode = 3'd1; ld_len = 14'd4; ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 32'h0000_0B00 + i;
      #1;
      chk("cnn_wr_en_cnn", wr_en_cnn, 1);
      chk("cnn_wr_addr_b0", wr_addr, i);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_start = 1'b1; ld_len = 14'd4; rd_start = 1'b1; rd_len = 14'd4;
    #1; chk("cnn_full_b0", bank_full, 2'b01);
    @(negedge clk); ld_start = 1'b0; rd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 32'h0000_0C00 + i;
      #1;
      chk("pp_wr_addr_b1", wr_addr, 8192 + i);
      chk("pp_wr_en_cnn", {wr_en_fc, wr_en_cnn}, 2'b01);
      chk("pp_rd_en", rd_en, 1);
      chk("pp_rd_addr", rd_addr, i);
      chk("pp_ptr_b0", weight_memory_pointer, 0);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    #1;
    chk("pp_ld_done", ld_done, 1);
    chk("pp_full_both", bank_full, 2'b11);
    chk("pp_drain", {rd_busy, rd_en}, 2'b10);
    @(negedge clk); #1;
    chk("pp_rd_done", rd_done, 1);
    chk("pp_full_b1", bank_full, 2'b10);
    rd_start = 1'b1; rd_len = 14'd2;
    @(negedge clk); rd_start = 1'b0; #1;
    chk("pp2_rd_en", rd_en, 1);
    chk("pp2_rd_addr0", rd_addr, 0);
    chk("pp2_ptr", weight_memory_pointer, 2048);
    @(negedge clk); #1;
    chk("pp2_rd_addr1", rd_addr, 1);
    @(negedge clk); #1;
    chk("pp2_ptr_drain", weight_memory_pointer, 2048);
    chk("pp2_drain_rd_en", rd_en, 0);
    @(negedge clk); #1;
    chk("pp2_rd_done", rd_done, 1);
    chk("pp2_empty", bank_full, 2'b00);
    do_reset();

    // ---- rd_stall on every other cycle, rd_len=8 ----
    mode = 3'd0; ld_len = 14'd1; ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1;
    @(negedge clk); ld_valid = 1'b0;
    rd_start = 1'b1; rd_len = 14'd8;
    @(negedge clk); rd_start = 1'b0;
    issued = 0; exp_addr = 0;
    for (int c = 0; c < 15; c++) begin
      rd_stall = (c % 2) == 1;
      #1;
      chk("stall_rd_en", rd_en, (c % 2) == 0);
      chk("stall_rd_addr", rd_addr, exp_addr);
      if (rd_en) begin
        issued++;
        exp_addr++;
      end
      @(negedge clk);
    end
    rd_stall = 1'b0;
    #1;
    chk("stall_drain", {rd_busy, rd_en}, 2'b10);
    chk("stall_issued", issued, 8);
    @(negedge clk); #1;
    chk("stall_rd_done", rd_done, 1);
    do_reset();

    // ---- illegal requests ----
    mode = 3'd0; ld_len = 14'd0; ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0; #1;
    chk("ill_len0_err", err, 1);
    chk("ill_len0_idle", {ld_busy, ld_ready, wr_en_fc, wr_en_cnn}, 0);
    rd_start = 1'b1; rd_len = 14'd1;
    @(negedge clk); rd_start = 1'b0; #1;
    chk("ill_empty_err", err, 1);
    chk("ill_empty_idle", {rd_busy, rd_en}, 0);
    @(negedge clk); #1;
    chk("ill_err_pulse", err, 0);
    mode = 3'd3; ld_len = 14'd4; ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0; mode = 3'd0; #1;
    chk("ill_mode3_ld_err", err, 1);
    chk("ill_mode3_ld_idle", ld_busy, 0);
    ld_len = 14'd1; ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1;
    @(negedge clk); ld_valid = 1'b0; #1;
    chk("ill_setup_full", bank_full, 2'b01);
    rd_start = 1'b1; rd_len = 14'd513;
    @(negedge clk); rd_start = 1'b0; #1;
    chk("ill_513_err", err, 1);
    chk("ill_513_idle", {rd_busy, rd_en}, 0);
    mode = 3'd3; rd_start = 1'b1; rd_len = 14'd1;
    @(negedge clk); rd_start = 1'b0; mode = 3'd0; #1;
    chk("ill_mode3_rd_err", err, 1);
    chk("ill_mode3_rd_idle", {rd_busy, rd_en}, 0);
    rd_start = 1'b1; rd_len = 14'd512;
    @(negedge clk); rd_start = 1'b0; #1;
    chk("len512_no_err", err, 0);
    chk("len512_running", {rd_busy, rd_en}, 2'b11);
    do_reset();

    // ---- same-cycle release + ld_start is accepted ----
    mode = 3'd0; ld_len = 14'd1; ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1;
    @(negedge clk); ld_valid = 1'b0; ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1; #1;
    chk("rel_wr_addr_b1", wr_addr, 8192);
    @(negedge clk); ld_valid = 1'b0; #1;
    chk("rel_full_both", bank_full, 2'b11);
    rd_start = 1'b1; rd_len = 14'd1;
    @(negedge clk); rd_start = 1'b0; ld_start = 1'b1; ld_len = 14'd2; #1;
    chk("rel_rd_en", rd_en, 1);
    @(negedge clk); #1;
    chk("rel_busy_reject_err", err, 1);
    @(negedge clk); ld_start = 1'b0; #1;
    chk("rel_accept_no_err", err, 0);
    chk("rel_ld_busy", ld_busy, 1);
    chk("rel_rd_done", rd_done, 1);
    chk("rel_full_b1", bank_full, 2'b10);
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      #1;
      chk("rel_wr_addr_b0", wr_addr, i);
      @(negedge clk);
    end
    ld_valid = 1'b0; #1;
    chk("rel_refilled", {ld_done, bank_full}, 3'b111);
    do_reset();

    // ---- load done with same-cycle rd_start is rejected ----
    mode = 3'd0; ld_len = 14'd2; ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1;
    @(negedge clk); rd_start = 1'b1; rd_len = 14'd1; #1;
    chk("race_last_wr", wr_en_fc, 1);
    @(negedge clk); ld_valid = 1'b0; rd_start = 1'b0; #1;
    chk("race_err", err, 1);
    chk("race_rd_idle", rd_busy, 0);
    chk("race_ld_done", ld_done, 1);
    chk("race_full", bank_full, 2'b01);
    rd_start = 1'b1;
    @(negedge clk); rd_start = 1'b0; #1;
    chk("race_retry_ok", {rd_busy, err}, 2'b10);
    do_reset();

    // ---- reset in the middle of a load at offset 5 ----
    mode = 3'd1; ld_len = 14'd10; ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = 32'h0000_0D00 + i;
      @(negedge clk);
    end
    ld_data = 32'h0000_0D05; #1;
    chk("mid_wr_addr5", wr_addr, 5);
    reset = 1'b0; #1;
    chk("mid_rst_wr", {wr_en_fc, wr_en_cnn, ld_ready, ld_busy}, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_bank_full", bank_full, 0);
    chk("mid_rst_rd", {rd_en, rd_addr, weight_memory_pointer}, 0);
    @(negedge clk); reset = 1'b1; ld_valid = 1'b0;
    @(negedge clk); #1;
    chk("mid_after_full", bank_full, 0);
    ld_len = 14'd1; ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1; #1;
    chk("mid_fill_bank0", wr_addr, 0);
    chk("mid_wr_en_cnn", wr_en_cnn, 1);
    @(negedge clk); ld_valid = 1'b0; #1;
    chk("mid_reload_full", bank_full, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
